// File: rtl/axi_ram_port_arb.sv
// -----------------------------------------------------------------------------
// axi_ram_port_arb
//
// Shares one AXI4 slave memory between two simple word-access requesters.
// One request is accepted at a time and turned into a single-beat AXI4 write
// (AW + W, then B) or read (AR, then R). The result comes back to the
// requester as a one-cycle rsp_valid pulse. At most one transaction is
// outstanding.
//
// Configuration macro:
//   ARB_FIXED_PRIO_EN  defined   -> port 0 has strict priority (port 1 may starve)
//                      undefined -> round-robin between the two ports (default)
//
// Ports (per-port buses are packed, port n occupies slice [n*W +: W]):
//   clk, rst                  clock, synchronous active-high reset
//   req_valid/req_ready [2]   request handshake per port (ready is combinational)
//   req_we [2]                1 = write, 0 = read
//   req_addr/wdata/wstrb      per-port byte address, write data, byte strobes
//   rsp_valid [2]             one-cycle completion pulse, no backpressure
//   rsp_rdata, rsp_err        shared read data and bresp/rresp[1]
//   m_axi_aw*/w*/b*/ar*/r*    AXI4 master port towards the RAM slave
// -----------------------------------------------------------------------------
module axi_ram_port_arb #(
  parameter int  DATA_WIDTH = 32,
  parameter int  ADDR_WIDTH = 8,
  parameter int  ID_WIDTH   = 8,
  localparam int STRB_WIDTH = DATA_WIDTH / 8
) (
  input  logic                    clk,
  input  logic                    rst,
  // requester side
  input  logic [1:0]              req_valid,
  output logic [1:0]              req_ready,
  input  logic [1:0]              req_we,
  input  logic [2*ADDR_WIDTH-1:0] req_addr,
  input  logic [2*DATA_WIDTH-1:0] req_wdata,
  input  logic [2*STRB_WIDTH-1:0] req_wstrb,
  output logic [1:0]              rsp_valid,
  output logic [DATA_WIDTH-1:0]   rsp_rdata,
  output logic                    rsp_err,
  // AXI write address
  output logic [ID_WIDTH-1:0]     m_axi_awid,
  output logic [ADDR_WIDTH-1:0]   m_axi_awaddr,
  output logic [7:0]              m_axi_awlen,
  output logic [2:0]              m_axi_awsize,
  output logic [1:0]              m_axi_awburst,
  output logic                    m_axi_awvalid,
  input  logic                    m_axi_awready,
  // AXI write data
  output logic [DATA_WIDTH-1:0]   m_axi_wdata,
  output logic [STRB_WIDTH-1:0]   m_axi_wstrb,
  output logic                    m_axi_wlast,
  output logic                    m_axi_wvalid,
  input  logic                    m_axi_wready,
  // AXI write response
  input  logic [ID_WIDTH-1:0]     m_axi_bid,
  input  logic [1:0]              m_axi_bresp,
  input  logic                    m_axi_bvalid,
  output logic                    m_axi_bready,
  // AXI read address
  output logic [ID_WIDTH-1:0]     m_axi_arid,
  output logic [ADDR_WIDTH-1:0]   m_axi_araddr,
  output logic [7:0]              m_axi_arlen,
  output logic [2:0]              m_axi_arsize,
  output logic [1:0]              m_axi_arburst,
  output logic                    m_axi_arvalid,
  input  logic                    m_axi_arready,
  // AXI read data
  input  logic [ID_WIDTH-1:0]     m_axi_rid,
  input  logic [DATA_WIDTH-1:0]   m_axi_rdata,
  input  logic [1:0]              m_axi_rresp,
  input  logic                    m_axi_rlast,
  input  logic                    m_axi_rvalid,
  output logic                    m_axi_rready
);

  localparam logic [2:0] AXSIZE      = 3'($clog2(STRB_WIDTH));
  localparam logic [1:0] BURST_INCR  = 2'b01;

  typedef enum logic [2:0] {
    S_IDLE,
    S_WR,    // AW and W outstanding
    S_WB,    // waiting for write response
    S_RD,    // AR outstanding
    S_RW,    // waiting for read data
    S_DONE   // response pulse to the requester
  } state_t;

  state_t state_q, state_d;

  logic                  grant_port;
  logic                  accept;
  logic                  aw_pend, w_pend;
  logic                  aw_clear, w_clear;

  logic                  lat_port;
  logic [ADDR_WIDTH-1:0] lat_addr;
  logic [DATA_WIDTH-1:0] lat_wdata;
  logic [STRB_WIDTH-1:0] lat_wstrb;

`ifndef ARB_FIXED_PRIO_EN
  logic                  rr_last;
`endif

  // Response IDs, the low response bits and rlast carry nothing this block
  // needs: every transfer is single-beat and only one is ever in flight.
  logic unused_inputs;
  assign unused_inputs = ^{m_axi_bid, m_axi_rid, m_axi_bresp[0], m_axi_rresp[0], m_axi_rlast};

  // ---------------------------------------------------------------------------
  // Arbitration
  // ---------------------------------------------------------------------------
  // NOTE: every signal written in an always_comb gets a default first, so no
  // path through the block leaves it unassigned and no latch is inferred.
  always_comb begin
    grant_port = 1'b0;
`ifdef ARB_FIXED_PRIO_EN
    grant_port = ~req_valid[0];
`else
    if (req_valid[0] && req_valid[1]) grant_port = ~rr_last;
    else                              grant_port = req_valid[1];
`endif
  end

  assign accept = (state_q == S_IDLE) && (|req_valid);

  // A write channel is clear once its handshake happened earlier or happens now.
  assign aw_clear = !aw_pend || m_axi_awready;
  assign w_clear  = !w_pend  || m_axi_wready;

  // ---------------------------------------------------------------------------
  // State register and control flags
  // ---------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      aw_pend   <= 1'b0;
      w_pend    <= 1'b0;
      rsp_rdata <= '0;
      rsp_err   <= 1'b0;
`ifndef ARB_FIXED_PRIO_EN
      rr_last   <= 1'b1;
`endif
    end else begin
      state_q <= state_d;
      if (accept) begin
        aw_pend <= req_we[grant_port];
        w_pend  <= req_we[grant_port];
`ifndef ARB_FIXED_PRIO_EN
        rr_last <= grant_port;
`endif
      end else begin
        if (aw_pend && m_axi_awready) aw_pend <= 1'b0;
        if (w_pend  && m_axi_wready)  w_pend  <= 1'b0;
      end
      if (state_q == S_WB && m_axi_bvalid) rsp_err <= m_axi_bresp[1];
      if (state_q == S_RW && m_axi_rvalid) begin
        rsp_rdata <= m_axi_rdata;
        rsp_err   <= m_axi_rresp[1];
      end
    end
  end

  // NOTE: the request latches are pure datapath and carry no reset; they are
  // only read after an accept has loaded them.
  always_ff @(posedge clk) begin
    if (accept) begin
      lat_port  <= grant_port;
      lat_addr  <= req_addr[grant_port*ADDR_WIDTH +: ADDR_WIDTH];
      lat_wdata <= req_wdata[grant_port*DATA_WIDTH +: DATA_WIDTH];
      lat_wstrb <= req_wstrb[grant_port*STRB_WIDTH +: STRB_WIDTH];
    end
  end

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE: if (accept) state_d = req_we[grant_port] ? S_WR : S_RD;
      S_WR:   if (aw_clear && w_clear) state_d = S_WB;
      S_WB:   if (m_axi_bvalid) state_d = S_DONE;
      S_RD:   if (m_axi_arready) state_d = S_RW;
      S_RW:   if (m_axi_rvalid) state_d = S_DONE;
      S_DONE: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  always_comb begin
    req_ready     = '0;
    rsp_valid     = '0;
    m_axi_arvalid = 1'b0;
    m_axi_bready  = 1'b0;
    m_axi_rready  = 1'b0;
    unique case (state_q)
      S_IDLE: if (|req_valid) req_ready[grant_port] = 1'b1;
      S_WB:   m_axi_bready  = 1'b1;
      S_RD:   m_axi_arvalid = 1'b1;
      S_RW:   m_axi_rready  = 1'b1;
      S_DONE: rsp_valid[lat_port] = 1'b1;
      default: ;
    endcase
  end

  assign m_axi_awvalid = aw_pend;
  assign m_axi_wvalid  = w_pend;

  assign m_axi_awid    = {{(ID_WIDTH-1){1'b0}}, lat_port};
  assign m_axi_awaddr  = lat_addr;
  assign m_axi_awlen   = 8'd0;
  assign m_axi_awsize  = AXSIZE;
  assign m_axi_awburst = BURST_INCR;

  assign m_axi_wdata   = lat_wdata;
  assign m_axi_wstrb   = lat_wstrb;
  assign m_axi_wlast   = 1'b1;

  assign m_axi_arid    = {{(ID_WIDTH-1){1'b0}}, lat_port};
  assign m_axi_araddr  = lat_addr;
  assign m_axi_arlen   = 8'd0;
  assign m_axi_arsize  = AXSIZE;
  assign m_axi_arburst = BURST_INCR;

endmodule

// File: tb/tb_axi_ram_port_arb.sv
// -----------------------------------------------------------------------------
// tb_axi_ram_port_arb
//
// Self-checking bench for axi_ram_port_arb. A behavioural AXI4 RAM slave with
// per-channel stall knobs and error injection sits on the master port; a
// word-array model of the memory provides expected read data.
// -----------------------------------------------------------------------------
module tb_axi_ram_port_arb;

  localparam int DW = 32;
  localparam int AW = 8;
  localparam int IW = 8;
  localparam int SW = DW / 8;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  // requester drive, one entry per port
  logic          rv[2];
  logic          rwe[2];
  logic [AW-1:0] raddr[2];
  logic [DW-1:0] rwdata[2];
  logic [SW-1:0] rwstrb[2];

  logic [1:0]    req_valid, req_ready, req_we, rsp_valid;
  logic [2*AW-1:0] req_addr;
  logic [2*DW-1:0] req_wdata;
  logic [2*SW-1:0] req_wstrb;
  logic [DW-1:0] rsp_rdata;
  logic          rsp_err;

  assign req_valid = {rv[1], rv[0]};
  assign req_we    = {rwe[1], rwe[0]};
  assign req_addr  = {raddr[1], raddr[0]};
  assign req_wdata = {rwdata[1], rwdata[0]};
  assign req_wstrb = {rwstrb[1], rwstrb[0]};

  logic [IW-1:0] awid, arid, bid, rid;
  logic [AW-1:0] awaddr, araddr;
  logic [7:0]    awlen, arlen;
  logic [2:0]    awsize, arsize;
  logic [1:0]    awburst, arburst, bresp, rresp;
  logic          awvalid, awready, wvalid, wready, wlast, bvalid, bready;
  logic          arvalid, arready, rvalid, rready, rlast;
  logic [DW-1:0] wdata, rdata;
  logic [SW-1:0] wstrb;

  axi_ram_port_arb dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_wstrb(req_wstrb),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .m_axi_awid(awid), .m_axi_awaddr(awaddr), .m_axi_awlen(awlen),
    .m_axi_awsize(awsize), .m_axi_awburst(awburst), .m_axi_awvalid(awvalid),
    .m_axi_awready(awready),
    .m_axi_wdata(wdata), .m_axi_wstrb(wstrb), .m_axi_wlast(wlast),
    .m_axi_wvalid(wvalid), .m_axi_wready(wready),
    .m_axi_bid(bid), .m_axi_bresp(bresp), .m_axi_bvalid(bvalid), .m_axi_bready(bready),
    .m_axi_arid(arid), .m_axi_araddr(araddr), .m_axi_arlen(arlen),
    .m_axi_arsize(arsize), .m_axi_arburst(arburst), .m_axi_arvalid(arvalid),
    .m_axi_arready(arready),
    .m_axi_rid(rid), .m_axi_rdata(rdata), .m_axi_rresp(rresp), .m_axi_rlast(rlast),
    .m_axi_rvalid(rvalid), .m_axi_rready(rready)
  );

  // ---------------------------------------------------------------------------
  // Behavioural AXI4 RAM slave
  // ---------------------------------------------------------------------------
  int aw_delay = 0, w_delay = 0, ar_delay = 0, b_delay = 0;
  bit rerr_inj = 1'b0, berr_inj = 1'b0;

  int            aw_wait, w_wait, ar_wait, b_wait;
  logic          aw_got, w_got, b_arm;
  logic [AW-1:0] s_awaddr;
  logic [DW-1:0] s_wdata;
  logic [SW-1:0] s_wstrb;
  logic [DW-1:0] smem[64];

  assign awready = awvalid && (aw_wait >= aw_delay);
  assign wready  = wvalid  && (w_wait  >= w_delay);
  assign arready = arvalid && (ar_wait >= ar_delay);
  assign rlast   = 1'b1;

  always @(posedge clk) begin
    if (rst) begin
      aw_wait <= 0; w_wait <= 0; ar_wait <= 0; b_wait <= 0;
      aw_got <= 1'b0; w_got <= 1'b0; b_arm <= 1'b0;
      bvalid <= 1'b0; rvalid <= 1'b0; bresp <= 2'b00; rresp <= 2'b00;
      bid <= '0; rid <= '0; rdata <= '0;
      for (int i = 0; i < 64; i++) smem[i] <= '0;
    end else begin
      if (awvalid) begin
        if (awready) begin
          aw_wait <= 0; aw_got <= 1'b1; s_awaddr <= awaddr; bid <= awid;
        end else aw_wait <= aw_wait + 1;
      end
      if (wvalid) begin
        if (wready) begin
          w_wait <= 0; w_got <= 1'b1; s_wdata <= wdata; s_wstrb <= wstrb;
        end else w_wait <= w_wait + 1;
      end
      if (aw_got && w_got) begin
        for (int i = 0; i < SW; i++)
          if (s_wstrb[i]) smem[s_awaddr[7:2]][8*i +: 8] <= s_wdata[8*i +: 8];
        aw_got <= 1'b0; w_got <= 1'b0; b_arm <= 1'b1; b_wait <= b_delay;
      end
      if (b_arm) begin
        if (b_wait == 0) begin
          bvalid <= 1'b1; bresp <= berr_inj ? 2'b10 : 2'b00; b_arm <= 1'b0;
        end else b_wait <= b_wait - 1;
      end
      if (bvalid && bready) bvalid <= 1'b0;
      if (rvalid && rready) rvalid <= 1'b0;
      if (arvalid) begin
        if (arready) begin
          ar_wait <= 0; rvalid <= 1'b1; rdata <= smem[araddr[7:2]];
          rresp <= rerr_inj ? 2'b10 : 2'b00; rid <= arid;
        end else ar_wait <= ar_wait + 1;
      end
    end
  end

  // Statistics and protocol observation (cumulative, not reset)
  int            aw_hs_cnt = 0, w_hs_cnt = 0;
  int            rsp_cnt[2] = '{0, 0};
  logic [IW-1:0] last_awid = '0, last_arid = '0;
  logic [2:0]    const_err = 3'b000;
  logic [2:0]    proto_err = 3'b000;
  logic          aw_stall_q = 1'b0, w_stall_q = 1'b0, ar_stall_q = 1'b0;

  always @(posedge clk) begin
    aw_stall_q <= !rst && awvalid && !awready;
    w_stall_q  <= !rst && wvalid  && !wready;
    ar_stall_q <= !rst && arvalid && !arready;
    if (!rst) begin
      if (rsp_valid[0]) rsp_cnt[0] <= rsp_cnt[0] + 1;
      if (rsp_valid[1]) rsp_cnt[1] <= rsp_cnt[1] + 1;
      if (aw_stall_q && !awvalid) proto_err[0] <= 1'b1;
      if (w_stall_q  && !wvalid)  proto_err[1] <= 1'b1;
      if (ar_stall_q && !arvalid) proto_err[2] <= 1'b1;
      if (awvalid && awready) begin
        aw_hs_cnt <= aw_hs_cnt + 1; last_awid <= awid;
        if (awlen != 8'd0 || awsize != 3'd2 || awburst != 2'b01) const_err[0] <= 1'b1;
      end
      if (wvalid && wready) begin
        w_hs_cnt <= w_hs_cnt + 1;
        if (wlast != 1'b1) const_err[1] <= 1'b1;
      end
      if (arvalid && arready) begin
        last_arid <= arid;
        if (arlen != 8'd0 || arsize != 3'd2 || arburst != 2'b01) const_err[2] <= 1'b1;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Reference memory model and checking helpers
  // ---------------------------------------------------------------------------
  logic [DW-1:0] model[64];
  int            grants[$];
  int            total = 0;
  int            bad   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [DW-1:0] merge(input logic [DW-1:0] old, input logic [DW-1:0] d,
                                          input logic [SW-1:0] s);
    logic [DW-1:0] r;
    r = old;
    for (int i = 0; i < SW; i++) if (s[i]) r[8*i +: 8] = d[8*i +: 8];
    return r;
  endfunction

  // Present a request on port p until it is accepted; called at a negedge.
  task automatic req_accept(input int p, input bit we, input logic [AW-1:0] a,
                            input logic [DW-1:0] d, input logic [SW-1:0] s, output bit ok);
    ok = 1'b0;
    rv[p] = 1'b1; rwe[p] = we; raddr[p] = a; rwdata[p] = d; rwstrb[p] = s;
    for (int c = 0; c < 300; c++) begin
      #1;
      if (req_ready[p]) begin
        ok = 1'b1;
        grants.push_back(p);
        @(negedge clk);
        break;
      end
      @(negedge clk);
    end
    rv[p] = 1'b0;
    if (!ok) check($sformatf("accept timeout port %0d", p), 32'd0, 32'd1);
  endtask

  task automatic wait_rsp(input int p, output logic [DW-1:0] rd, output bit er, output bit ok);
    ok = 1'b0; rd = '0; er = 1'b0;
    for (int c = 0; c < 300; c++) begin
      @(negedge clk);
      if (rsp_valid[p]) begin
        ok = 1'b1; rd = rsp_rdata; er = rsp_err;
        break;
      end
    end
    if (!ok) check($sformatf("response timeout port %0d", p), 32'd0, 32'd1);
  endtask

  task automatic run_txn(input int p, input bit we, input logic [AW-1:0] a,
                         input logic [DW-1:0] d, input logic [SW-1:0] s,
                         input bit rerr, input bit berr,
                         output logic [DW-1:0] rd, output bit er, output bit ok);
    rerr_inj = rerr; berr_inj = berr;
    rd = '0; er = 1'b0;
    req_accept(p, we, a, d, s, ok);
    if (ok) wait_rsp(p, rd, er, ok);
    if (ok && we) model[a[7:2]] = merge(model[a[7:2]], d, s);
  endtask

  // ---------------------------------------------------------------------------
  // Directed vectors
  // ---------------------------------------------------------------------------
  typedef struct {
    int            port;
    bit            we;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
    logic [SW-1:0] wstrb;
    bit            rerr;
    logic [DW-1:0] exp_rdata;
    bit            exp_err;
  } vec_t;

  vec_t vecs[8];

  task automatic stream(input int p, input int n);
    logic [DW-1:0] rd; bit er; bit ok;
    for (int k = 0; k < n; k++) begin
      run_txn(p, 1'b0, 8'h10, '0, '0, 1'b0, 1'b0, rd, er, ok);
      if (ok) check($sformatf("stream p%0d data", p), rd, model[4]);
    end
  endtask

  initial begin
    logic [DW-1:0] rd;
    bit            er, ok;
    int            aw0, w0, r0;

    vecs[0] = '{0, 1'b1, 8'h10, 32'h11223344, 4'hF, 1'b0, 32'h0,        1'b0};
    vecs[1] = '{0, 1'b0, 8'h10, 32'h0,        4'h0, 1'b0, 32'h11223344, 1'b0};
    vecs[2] = '{1, 1'b1, 8'h20, 32'hAABBCCDD, 4'h3, 1'b0, 32'h0,        1'b0};
    vecs[3] = '{1, 1'b0, 8'h20, 32'h0,        4'h0, 1'b0, 32'h0000CCDD, 1'b0};
    vecs[4] = '{1, 1'b0, 8'h10, 32'h0,        4'h0, 1'b1, 32'h11223344, 1'b1};
    vecs[5] = '{0, 1'b0, 8'h20, 32'h0,        4'h0, 1'b0, 32'h0000CCDD, 1'b0};
    vecs[6] = '{0, 1'b1, 8'h10, 32'hDEADBEEF, 4'hC, 1'b0, 32'h0,        1'b0};
    vecs[7] = '{1, 1'b0, 8'h10, 32'h0,        4'h0, 1'b0, 32'hDEAD3344, 1'b0};

    for (int p = 0; p < 2; p++) begin
      rv[p] = 1'b0; rwe[p] = 1'b0; raddr[p] = '0; rwdata[p] = '0; rwstrb[p] = '0;
    end
    for (int i = 0; i < 64; i++) model[i] = '0;

    // ---- reset state ----
    rst = 1'b1;
    repeat (3) @(negedge clk);
    check("reset awvalid", awvalid, 0);
    check("reset wvalid", wvalid, 0);
    check("reset arvalid", arvalid, 0);
    check("reset bready", bready, 0);
    check("reset rready", rready, 0);
    check("reset rsp_valid", rsp_valid, 0);
    check("reset rsp_rdata", rsp_rdata, 0);
    check("reset rsp_err", rsp_err, 0);
    rst = 1'b0;
    @(negedge clk);

    // ---- both ports requesting continuously: port 0 is preferred first ----
    grants.delete();
    fork
      stream(0, 6);
      stream(1, 6);
    join
    check("arb grant count", grants.size(), 12);
    for (int k = 0; k < 6 && k < grants.size(); k++) begin
`ifdef ARB_FIXED_PRIO_EN
      check($sformatf("arb grant %0d", k), grants[k], 0);
`else
      check($sformatf("arb grant %0d", k), grants[k], k % 2);
`endif
    end

    // ---- directed table ----
    for (int i = 0; i < 8; i++) begin
      run_txn(vecs[i].port, vecs[i].we, vecs[i].addr, vecs[i].wdata, vecs[i].wstrb,
              vecs[i].rerr, 1'b0, rd, er, ok);
      if (ok) begin
        if (!vecs[i].we) begin
          check($sformatf("vec %0d rdata", i), rd, vecs[i].exp_rdata);
          check($sformatf("vec %0d arid", i), last_arid, vecs[i].port);
        end else begin
          check($sformatf("vec %0d awid", i), last_awid, vecs[i].port);
        end
        check($sformatf("vec %0d err", i), er, vecs[i].exp_err);
      end
    end

    // ---- slave stalls: AW late / W late, one handshake each, one pulse ----
    for (int m = 0; m < 2; m++) begin
      aw_delay = (m == 0) ? 3 : 0;
      w_delay  = (m == 0) ? 0 : 3;
      aw0 = aw_hs_cnt; w0 = w_hs_cnt; r0 = rsp_cnt[0];
      run_txn(0, 1'b1, 8'h40 + 8'(4*m), 32'hC0DE0000 + m, 4'hF, 1'b0, 1'b0, rd, er, ok);
      repeat (3) @(negedge clk);
      check($sformatf("stall %0d aw handshakes", m), aw_hs_cnt - aw0, 1);
      check($sformatf("stall %0d w handshakes", m), w_hs_cnt - w0, 1);
      check($sformatf("stall %0d rsp pulses", m), rsp_cnt[0] - r0, 1);
    end
    aw_delay = 0; w_delay = 0; ar_delay = 3;
    run_txn(1, 1'b0, 8'h44, '0, '0, 1'b0, 1'b0, rd, er, ok);
    if (ok) check("stall ar rdata", rd, 32'hC0DE0001);
    ar_delay = 0;

    // ---- reset while waiting for the write response ----
    b_delay = 30;
    req_accept(0, 1'b1, 8'h30, 32'h5A5A5A5A, 4'hF, ok);
    ok = 1'b0;
    for (int c = 0; c < 50; c++) begin
      if (bready) begin ok = 1'b1; break; end
      @(negedge clk);
    end
    check("reached write response wait", ok, 1);
    r0 = rsp_cnt[0];
    rst = 1'b1;
    @(negedge clk);
    check("mid reset awvalid", awvalid, 0);
    check("mid reset wvalid", wvalid, 0);
    check("mid reset arvalid", arvalid, 0);
    check("mid reset bready", bready, 0);
    check("mid reset rready", rready, 0);
    check("mid reset rsp_valid", rsp_valid, 0);
    rst = 1'b0;
    b_delay = 0;
    for (int i = 0; i < 64; i++) model[i] = '0;
    @(negedge clk);
    run_txn(1, 1'b0, 8'h20, '0, '0, 1'b0, 1'b0, rd, er, ok);
    if (ok) begin
      check("post reset rdata", rd, 32'h0);
      check("post reset err", er, 0);
      check("post reset arid", last_arid, 1);
    end
    check("abandoned write has no response", rsp_cnt[0] - r0, 0);

    // ---- randomized traffic against the memory model ----
    for (int n = 0; n < 40; n++) begin
      int            p;
      bit            we, rerr, berr;
      logic [AW-1:0] a;
      logic [DW-1:0] d;
      logic [SW-1:0] s;
      p    = int'($urandom_range(0, 1));
      we   = 1'($urandom_range(0, 1));
      a    = 8'($urandom_range(0, 63) * 4);
      d    = $urandom;
      s    = 4'($urandom_range(0, 15));
      rerr = !we && ($urandom_range(0, 4) == 0);
      berr = we && ($urandom_range(0, 5) == 0);
      aw_delay = int'($urandom_range(0, 2));
      w_delay  = int'($urandom_range(0, 2));
      ar_delay = int'($urandom_range(0, 2));
      b_delay  = int'($urandom_range(0, 2));
      if (!we) rd = model[a[7:2]];
      begin
        logic [DW-1:0] exp_rd;
        exp_rd = model[a[7:2]];
        run_txn(p, we, a, d, s, rerr, berr, rd, er, ok);
        if (ok) begin
          if (!we) begin
            check($sformatf("rand %0d rdata", n), rd, exp_rd);
            check($sformatf("rand %0d arid", n), last_arid, p);
          end else begin
            check($sformatf("rand %0d awid", n), last_awid, p);
          end
          check($sformatf("rand %0d err", n), er, we ? berr : rerr);
        end
      end
    end

    check("axi constant fields", const_err, 3'b000);
    check("axi valid withdrawn before ready", proto_err, 3'b000);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
